// File: rtl/sevenseg_pkg.sv
// sevenseg_pkg: shared states, blank segment constant and pin polarity helper
package sevenseg_pkg;
    typedef enum logic {BLANK, DRIVE} scan_state_e;
    typedef enum logic {HS_OPEN, HS_HELD} hs_state_e;
    localparam logic [7:0] SEG_BLANK = 8'h00;
    function automatic logic [7:0] seg_pol(input logic [7:0] x, input bit active_low);
        return active_low ? ~x : x;
    endfunction
endpackage

// File: rtl/scan_tick_gen.sv
// scan_tick_gen: slot counter and digit index driving the display scan
module scan_tick_gen #(
    parameter int NUM_DIGITS   = 4,
    parameter int SLOT_CYCLES  = 65536,
    parameter int BLANK_CYCLES = 256,
    parameter int DW           = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic [DW-1:0] digit_idx,
    output logic          slot_wrap,
    output logic          frame_wrap,
    output logic          frame_head,
    output logic          in_blank,
    output logic [3:0]    pwm_phase
);
    localparam int CW = $clog2(SLOT_CYCLES);
    logic [CW-1:0] slot_cnt;
    assign slot_wrap  = slot_cnt == CW'(SLOT_CYCLES - 1);
    assign frame_wrap = slot_wrap && digit_idx == DW'(NUM_DIGITS - 1);
    assign frame_head = slot_cnt == '0 && digit_idx == '0;
    assign in_blank   = slot_cnt < CW'(BLANK_CYCLES);
    assign pwm_phase  = slot_cnt[3:0];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_cnt  <= '0;
            digit_idx <= '0;
        end else begin
            slot_cnt <= slot_wrap ? '0 : slot_cnt + CW'(1);
            if (slot_wrap) digit_idx <= frame_wrap ? '0 : digit_idx + DW'(1);
        end
    end
endmodule

// File: rtl/sevenseg_scan_ctrl.sv
// sevenseg_scan_ctrl: multiplexed seven-segment driver with blanking, PWM dimming
// and frame-synchronous data loading
module sevenseg_scan_ctrl
    import sevenseg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int SLOT_CYCLES  = 65536,
    parameter int BLANK_CYCLES = 256,
    parameter bit ACTIVE_LOW   = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [8*NUM_DIGITS-1:0] load_data,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic [3:0]              brightness,
    output logic [7:0]              seg_out,
    output logic [NUM_DIGITS-1:0]   an_out,
    output logic                    frame_start
);
    localparam int DW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
    logic [DW-1:0] digit_idx;
    logic slot_wrap, frame_wrap, frame_head, in_blank;
    logic [3:0] pwm_phase;
    scan_tick_gen #(
        .NUM_DIGITS  (NUM_DIGITS),
        .SLOT_CYCLES (SLOT_CYCLES),
        .BLANK_CYCLES(BLANK_CYCLES),
        .DW          (DW)
    ) u_tick (
        .clk       (clk),
        .rst_n     (rst_n),
        .digit_idx (digit_idx),
        .slot_wrap (slot_wrap),
        .frame_wrap(frame_wrap),
        .frame_head(frame_head),
        .in_blank  (in_blank),
        .pwm_phase (pwm_phase)
    );
    logic [NUM_DIGITS-1:0][7:0] active_buf, pending_buf;
    hs_state_e hs_q, hs_d;
    scan_state_e scan_state;
    logic xfer, commit, an_on;
    logic [7:0] seg_d;
    logic [NUM_DIGITS-1:0] an_d;
    assign scan_state = in_blank ? BLANK : DRIVE;
    assign load_ready = hs_q == HS_OPEN;
    assign xfer       = load_valid && load_ready;
    assign commit     = hs_q == HS_HELD && frame_wrap;
    always_comb begin
        hs_d = hs_q;
        if (xfer) hs_d = HS_HELD;
        else if (commit) hs_d = HS_OPEN;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) hs_q <= HS_OPEN;
        else hs_q <= hs_d;
    end
    // pending only moves to active as digit_idx wraps, so a frame never tears
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_buf <= {NUM_DIGITS{SEG_BLANK}};
            active_buf  <= {NUM_DIGITS{SEG_BLANK}};
        end else begin
            if (xfer) pending_buf <= load_data;
            if (commit) active_buf <= pending_buf;
        end
    end
    always_comb begin
        an_on = scan_state == DRIVE && digit_en[digit_idx] && pwm_phase <= brightness;
        seg_d = scan_state == DRIVE ? active_buf[digit_idx] : SEG_BLANK;
        an_d  = an_on ? NUM_DIGITS'(1) << digit_idx : '0;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_out     <= seg_pol(SEG_BLANK, ACTIVE_LOW);
            an_out      <= ACTIVE_LOW ? '1 : '0;
            frame_start <= 1'b0;
        end else begin
            seg_out     <= seg_pol(seg_d, ACTIVE_LOW);
            an_out      <= ACTIVE_LOW ? ~an_d : an_d;
            frame_start <= frame_head;
        end
    end
endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// tb_sevenseg_scan_ctrl: table vectors, corner sequences and a frame-level reference
// model checked every cycle for the scan controller
module tb_sevenseg_scan_ctrl;
    localparam int ND = 4, SLOT = 64, BLK = 4, FRAME = ND * SLOT;
    logic clk = 0, rst_n = 1;
    logic [31:0] load_data = '0;
    logic load_valid = 0, load_ready;
    logic [3:0] digit_en = 4'hF, brightness = 4'd15;
    logic [7:0] seg_out;
    logic [3:0] an_out;
    logic frame_start;
    sevenseg_scan_ctrl #(
        .NUM_DIGITS(ND), .SLOT_CYCLES(SLOT), .BLANK_CYCLES(BLK), .ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .load_data(load_data), .load_valid(load_valid),
        .load_ready(load_ready), .digit_en(digit_en), .brightness(brightness),
        .seg_out(seg_out), .an_out(an_out), .frame_start(frame_start)
    );
    always #5 clk = ~clk;
    int checks = 0, errors = 0;
    int k;
    logic [31:0] m_active, m_pending;
    logic m_ready, last_xfer;
    logic [7:0] e_seg;
    logic [3:0] e_an;
    logic e_fs;
    typedef struct {
        logic v; logic [31:0] d; logic [3:0] en, br;
        logic [7:0] seg; logic [3:0] an; logic rdy, fs;
    } rst_vec_t;
    typedef struct {
        logic [3:0] en, br; int pos;
        logic [3:0] an; logic [7:0] seg;
    } scan_vec_t;
    rst_vec_t rv[4];
    scan_vec_t sv[12];
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h (k=%0d)", name, act, exp, k);
        end
    endtask
    // Model: after k edges the pins show frame position (k-1) mod FRAME
    task automatic step();
        logic v; logic [31:0] d; logic [3:0] en, br;
        int c, sl, dg;
        logic drv;
        v = load_valid; d = load_data; en = digit_en; br = brightness;
        c = k % FRAME; sl = c % SLOT; dg = c / SLOT; drv = sl >= BLK;
        e_seg = drv ? ~m_active[dg*8 +: 8] : 8'hFF;
        e_an = 4'hF;
        if (drv && en[dg] && (sl % 16) <= int'(br)) e_an[dg] = 1'b0;
        e_fs = c == 0;
        last_xfer = v && m_ready;
        if (last_xfer) begin
            m_pending = d;
            m_ready = 0;
        end else if (!m_ready && c == FRAME - 1) begin
            m_active = m_pending;
            m_ready = 1;
        end
        k++;
        @(posedge clk);
        #1;
        chk("seg_out", 32'(seg_out), 32'(e_seg));
        chk("an_out", 32'(an_out), 32'(e_an));
        chk("frame_start", 32'(frame_start), 32'(e_fs));
        chk("load_ready", 32'(load_ready), 32'(m_ready));
    endtask
    task automatic wait_pos(input int p);
        int n = 0;
        while (!(k > 0 && (k - 1) % FRAME == p) && n < FRAME + 8) begin
            step();
            n++;
        end
        if (n >= FRAME + 8) begin
            checks++;
            errors++;
            $display("FAIL wait_pos timeout got %0d expected %0d", n, p);
        end
    endtask
    task automatic model_reset();
        k = 0; m_active = '0; m_pending = '0; m_ready = 1; last_xfer = 0;
    endtask
    task automatic async_reset(input string tag);
        #2 rst_n = 0;
        #1;
        chk({tag, "_seg"}, 32'(seg_out), 32'hFF);
        chk({tag, "_an"}, 32'(an_out), 32'hF);
        chk({tag, "_rdy"}, 32'(load_ready), 32'h1);
        chk({tag, "_fs"}, 32'(frame_start), 32'h0);
        load_valid = 0;
        model_reset();
    endtask
    initial begin
        int gap, fs_k, cnt0, cnt1, exp_pwm;
        foreach (rv[i]) begin
            rv[i].v = 1'($urandom); rv[i].d = $urandom;
            rv[i].en = 4'($urandom); rv[i].br = 4'($urandom);
            rv[i].seg = 8'hFF; rv[i].an = 4'hF; rv[i].rdy = 1; rv[i].fs = 0;
        end
        sv[0]  = '{4'hF, 4'd15, 10,          4'hE, 8'hB0};
        sv[1]  = '{4'hF, 4'd15, SLOT + 10,   4'hD, 8'hA4};
        sv[2]  = '{4'hF, 4'd15, 2*SLOT + 10, 4'hB, 8'hF9};
        sv[3]  = '{4'hF, 4'd15, 3*SLOT + 10, 4'h7, 8'hC0};
        sv[4]  = '{4'hF, 4'd15, 2,           4'hF, 8'hFF};
        sv[5]  = '{4'h5, 4'd0,  16,          4'hE, 8'hB0};
        sv[6]  = '{4'h5, 4'd0,  17,          4'hF, 8'hB0};
        sv[7]  = '{4'h5, 4'd0,  SLOT + 16,   4'hF, 8'hA4};
        sv[8]  = '{4'h5, 4'd0,  2*SLOT + 32, 4'hB, 8'hF9};
        sv[9]  = '{4'hF, 4'd7,  3*SLOT + 23, 4'h7, 8'hC0};
        sv[10] = '{4'hF, 4'd7,  3*SLOT + 24, 4'hF, 8'hC0};
        sv[11] = '{4'hF, 4'd7,  SLOT + 3,    4'hF, 8'hFF};
        model_reset();
        // reset holds pins inactive whatever the inputs do
        async_reset("rst0");
        foreach (rv[i]) begin
            load_valid = rv[i].v; load_data = rv[i].d; digit_en = rv[i].en; brightness = rv[i].br;
            @(posedge clk);
            #1;
            chk("rst_seg", 32'(seg_out), 32'(rv[i].seg));
            chk("rst_an", 32'(an_out), 32'(rv[i].an));
            chk("rst_rdy", 32'(load_ready), 32'(rv[i].rdy));
            chk("rst_fs", 32'(frame_start), 32'(rv[i].fs));
        end
        load_valid = 0; digit_en = 4'hF; brightness = 4'd15;
        rst_n = 1;
        model_reset();
        load_data = 32'h3F065B4F; load_valid = 1;
        step();
        load_valid = 0;
        wait_pos(SLOT + 1);
        wait_pos(0);
        foreach (sv[i]) begin
            digit_en = sv[i].en; brightness = sv[i].br;
            step();
            wait_pos(sv[i].pos);
            chk("vec_an", 32'(an_out), 32'(sv[i].an));
            chk("vec_seg", 32'(seg_out), 32'(sv[i].seg));
        end
        // blanking gaps and frame_start period at full brightness
        digit_en = 4'hF; brightness = 4'd15;
        step();
        wait_pos(FRAME - 1);
        gap = 0; fs_k = -1; cnt0 = 0;
        for (int i = 0; i < FRAME; i++) begin
            step();
            if (an_out == 4'hF && seg_out == 8'hFF) gap++;
            if (frame_start) begin
                if (fs_k >= 0) chk("fs_period", 32'(k - fs_k), FRAME);
                fs_k = k;
            end
        end
        chk("blank_cycles", 32'(gap), ND * BLK);
        step();
        wait_pos(0);
        chk("fs_period", 32'(k - fs_k), FRAME);
        // PWM at minimum duty with digits 1 and 3 masked
        digit_en = 4'b0101; brightness = 4'd0;
        wait_pos(FRAME - 1);
        cnt0 = 0; cnt1 = 0; exp_pwm = 0;
        for (int s = BLK; s < SLOT; s++) if (s % 16 == 0) exp_pwm++;
        for (int i = 0; i < FRAME; i++) begin
            step();
            if (!an_out[0]) cnt0++;
            if (!an_out[1] || !an_out[3]) cnt1++;
        end
        chk("pwm_dig0_on", 32'(cnt0), 32'(exp_pwm));
        chk("masked_on", 32'(cnt1), 32'h0);
        // tear-free load issued during the digit-2 slot
        digit_en = 4'hF; brightness = 4'd15;
        wait_pos(2*SLOT + 20);
        load_data = 32'h11223344; load_valid = 1;
        step();
        load_valid = 0;
        chk("tear_rdy_low", 32'(load_ready), 32'h0);
        wait_pos(2*SLOT + 40);
        chk("tear_old_d2", 32'(seg_out), 32'hF9);
        wait_pos(3*SLOT + 40);
        chk("tear_old_d3", 32'(seg_out), 32'hC0);
        wait_pos(FRAME - 2);
        chk("tear_rdy_hold", 32'(load_ready), 32'h0);
        wait_pos(0);
        chk("tear_rdy_commit", 32'(load_ready), 32'h1);
        wait_pos(10);
        chk("tear_new_d0", 32'(seg_out), 32'hBB);
        wait_pos(SLOT + 10);
        chk("tear_new_d1", 32'(seg_out), 32'hCC);
        // reset during digit-1 drive with a load pending
        wait_pos(SLOT + 20);
        load_data = 32'hAABBCCDD; load_valid = 1;
        step();
        load_valid = 0;
        step();
        async_reset("rst_mid");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1;
        wait_pos(10);
        chk("post_rst_seg", 32'(seg_out), 32'hFF);
        chk("post_rst_an", 32'(an_out), 32'hE);
        wait_pos(SLOT + 1);
        wait_pos(10);
        chk("pending_lost", 32'(seg_out), 32'hFF);
        // randomized traffic; upstream holds valid until accepted
        for (int i = 0; i < 3000; i++) begin
            if (last_xfer) load_valid = 0;
            if (!load_valid && $urandom_range(0, 15) == 0) begin
                load_valid = 1;
                load_data = $urandom;
            end
            if ($urandom_range(0, 63) == 0) begin
                digit_en = 4'($urandom);
                brightness = 4'($urandom);
            end
            step();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
